sigmul_pipe: RTL

SIGMUL_PIPE -- requirements
Module: sigmul_pipe

---
 rtl/sigmul_pkg.sv | 52 +++++
 rtl/sigmul_booth_pp.sv | 44 ++++
 rtl/sigmul_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sigmul_pkg.sv
// Shared sizing helpers and Booth digit encoding for the pipelined significand multiplier.
package sigmul_pkg;

    typedef enum logic [2:0] {
        BoothZero = 3'd0,
        BoothPos1 = 3'd1,
        BoothPos2 = 3'd2,
        BoothNeg2 = 3'd3,
        BoothNeg1 = 3'd4
    } booth_digit_e;

    function automatic int unsigned nbbits(input int unsigned nsig);
        return nsig + 3 + (nsig % 2);
    endfunction

    function automatic int unsigned npps(input int unsigned nsig);
        return nbbits(nsig) / 2;
    endfunction

    function automatic int unsigned prod_width(input int unsigned nsig);
        return 2 * nsig + 2;
    endfunction

    // Vectors remaining after lvl rounds of 3:2 compression starting from n.
    function automatic int unsigned csa_count(input int unsigned n, input int unsigned lvl);
        int unsigned c = n;
        for (int unsigned k = 0; k < lvl; k++) c = (c / 3) * 2 + c % 3;
        return c;
    endfunction

    function automatic int unsigned csa_levels(input int unsigned n);
        int unsigned c = n;
        int unsigned l = 0;
        while (c > 2) begin
            c = (c / 3) * 2 + c % 3;
            l++;
        end
        return l;
    endfunction

    // Triple is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_e booth_decode(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return BoothPos1;
            3'b011:         return BoothPos2;
            3'b100:         return BoothNeg2;
            3'b101, 3'b110: return BoothNeg1;
            default:        return BoothZero;
        endcase
    endfunction

endpackage

// File: rtl/sigmul_booth_pp.sv
// Radix-4 Booth recoder and partial-product mux; purely combinational.
module sigmul_booth_pp
    import sigmul_pkg::*;
#(
    parameter int unsigned NSIG = 10
) (
    input  logic [NSIG:0]                      a,
    input  logic [NSIG:0]                      b,
    output logic [npps(NSIG)-1:0][NSIG+2:0]    pp
);

    localparam int unsigned NPPS = npps(NSIG);
    localparam int unsigned BXW  = 2 * NPPS + 1;

    logic [BXW-1:0]  bx;
    logic [NSIG+2:0] a1;
    logic [NSIG+2:0] a2;

    // bx[0] is the implicit zero at bit -1; upper zeros keep the top digit non-negative.
    assign bx = {{(BXW - NSIG - 2){1'b0}}, b, 1'b0};
    assign a1 = {2'b00, a};
    assign a2 = {1'b0, a, 1'b0};

    for (genvar i = 0; i < NPPS; i++) begin : g_pp
        booth_digit_e    dig;
        logic [NSIG+2:0] val;

        assign dig = booth_decode(bx[2*i +: 3]);

        always_comb begin
            val = '0;
            unique case (dig)
                BoothPos1: val = a1;
                BoothPos2: val = a2;
                BoothNeg2: val = -a2;
                BoothNeg1: val = -a1;
                default:   val = '0;
            endcase
        end

        assign pp[i] = val;
    end

endmodule

// File: rtl/sigmul_pipe.sv
// Three-stage exact unsigned significand multiplier: Booth PPs, CSA tree, final adder.
module sigmul_pipe
    import sigmul_pkg::*;
#(
    parameter int unsigned NSIG = 10,
    parameter int unsigned TAGW = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NSIG:0]               a,
    input  logic [NSIG:0]               b,
    input  logic [TAGW-1:0]             in_tag,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [prod_width(NSIG)-1:0] p,
    output logic [TAGW-1:0]             out_tag
);

    localparam int unsigned NPPS = npps(NSIG);
    localparam int unsigned PW   = prod_width(NSIG);
    localparam int unsigned NLVL = csa_levels(NPPS);

    typedef logic [NPPS-1:0][NSIG+2:0] pp_t;

    pp_t           pp_d;
    pp_t           pp1_q;
    logic          v1_q, v2_q, v3_q;
    logic [TAGW-1:0] tag1_q, tag2_q, tag3_q;
    logic [PW-1:0] sum2_q, carry2_q, p3_q;
    logic          ld1, ld2, ld3;

    sigmul_booth_pp #(
        .NSIG (NSIG)
    ) u_booth (
        .a  (a),
        .b  (b),
        .pp (pp_d)
    );

    // A stage may load when empty or when its occupant moves on this cycle.
    assign ld3      = !v3_q || out_ready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1;

    // Level 0 holds the weighted, sign-extended partial products; everything is mod 2^PW.
    logic [PW-1:0] tree [NLVL+1][NPPS];

    for (genvar i = 0; i < NPPS; i++) begin : g_lvl0
        localparam int unsigned SH = 2 * i;
        assign tree[0][i] = PW'($signed(pp1_q[i])) << SH;
    end

    for (genvar l = 1; l <= NLVL; l++) begin : g_lvl
        localparam int unsigned M = csa_count(NPPS, l - 1);
        localparam int unsigned G = M / 3;
        localparam int unsigned R = M % 3;
        localparam int unsigned N = 2 * G + R;

        for (genvar g = 0; g < G; g++) begin : g_csa
            logic [PW-1:0] x, y, z;
            assign x = tree[l-1][3*g];
            assign y = tree[l-1][3*g+1];
            assign z = tree[l-1][3*g+2];
            assign tree[l][2*g]   = x ^ y ^ z;
            assign tree[l][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
        end

        for (genvar r = 0; r < R; r++) begin : g_pass
            assign tree[l][2*G+r] = tree[l-1][3*G+r];
        end

        for (genvar k = N; k < NPPS; k++) begin : g_zero
            assign tree[l][k] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            pp1_q  <= '0;
            tag1_q <= '0;
        end else if (ld1) begin
            v1_q <= in_valid;
            if (in_valid) begin
                pp1_q  <= pp_d;
                tag1_q <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q     <= 1'b0;
            sum2_q   <= '0;
            carry2_q <= '0;
            tag2_q   <= '0;
        end else if (ld2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                sum2_q   <= tree[NLVL][0];
                carry2_q <= tree[NLVL][1];
                tag2_q   <= tag1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q   <= 1'b0;
            p3_q   <= '0;
            tag3_q <= '0;
        end else if (ld3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                p3_q   <= sum2_q + carry2_q;
                tag3_q <= tag2_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign p         = p3_q;
    assign out_tag   = tag3_q;

endmodule
